// File: rtl/l2_inval_dispatch_pkg.sv
// Shared definitions for the L2 invalidation dispatcher: sizing, row-index field, FSM states.
package l2_inval_dispatch_pkg;

  localparam int NPROC   = 4;
  localparam int IDX_W   = (NPROC > 1) ? $clog2(NPROC) : 1;
  localparam int ROW_LSB = 4;
  localparam int ROW_MSB = 13;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    WAIT_ACK,
    CLEAR,
    DONE
  } state_t;

  function automatic logic [NPROC-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [NPROC-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/l2_inval_dispatch_lowest_set_bit.sv
// Priority encoder: index of the lowest set bit of a vector, plus an any-set flag.
module l2_inval_dispatch_lowest_set_bit #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     vec_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  // Walking downward lets the lowest set bit be the final writer.
  always_comb begin
    idx_o = '0;
    any_o = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec_i[i]) begin
        idx_o = IDX_W'(i);
        any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/l2_inval_dispatch.sv
// Sends one invalidation per sharing L1 (ascending order), then one sharer-clear command to L2.
module l2_inval_dispatch #(
  parameter int NPROC   = 4,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_valid,
  output logic              start_ready,
  input  logic [NPROC-1:0]  sharers,
  input  logic [1:0]        writer,
  input  logic [ADDR_W-1:0] addr,
  output logic [NPROC-1:0]  inv_valid,
  output logic [ADDR_W-1:0] inv_addr,
  input  logic [NPROC-1:0]  inv_ack,
  output logic              clr_valid,
  output logic [9:0]        clr_row,
  output logic [NPROC-1:0]  clr_mask,
  output logic              done,
  output logic              err
);
  import l2_inval_dispatch_pkg::*;

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  state_t            state_q;
  logic [NPROC-1:0]  pending_q;
  logic [NPROC-1:0]  acked_q;
  logic              err_flag_q;
  logic [IDX_W-1:0]  idx_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic [ADDR_W-1:0] addr_q;

  logic [NPROC-1:0]  inv_valid_q;
  logic [ADDR_W-1:0] inv_addr_q;
  logic              clr_valid_q;
  logic [9:0]        clr_row_q;
  logic [NPROC-1:0]  clr_mask_q;
  logic              done_q;
  logic              err_q;

  logic [IDX_W-1:0]  lsb_idx;
  logic              lsb_any;

  l2_inval_dispatch_lowest_set_bit #(
    .N     (NPROC),
    .IDX_W (IDX_W)
  ) u_lsb (
    .vec_i (pending_q),
    .idx_o (lsb_idx),
    .any_o (lsb_any)
  );

  // Saturating wait counter; the value after this cycle decides the timeout.
  assign cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

  assign start_ready = (state_q == IDLE) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pending_q   <= '0;
      acked_q     <= '0;
      err_flag_q  <= 1'b0;
      idx_q       <= '0;
      cnt_q       <= '0;
      inv_valid_q <= '0;
      inv_addr_q  <= '0;
      clr_valid_q <= 1'b0;
      clr_row_q   <= '0;
      clr_mask_q  <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      clr_valid_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_valid) begin
            pending_q  <= sharers & ~onehot(writer);
            addr_q     <= addr;
            acked_q    <= '0;
            err_flag_q <= 1'b0;
            state_q    <= SCAN;
          end
        end
        SCAN: begin
          if (!lsb_any) begin
            if (acked_q != '0) begin
              clr_valid_q <= 1'b1;
              clr_row_q   <= addr_q[ROW_MSB:ROW_LSB];
              clr_mask_q  <= acked_q;
            end
            state_q <= CLEAR;
          end else begin
            idx_q       <= lsb_idx;
            cnt_q       <= '0;
            inv_valid_q <= onehot(lsb_idx);
            inv_addr_q  <= addr_q;
            state_q     <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          // An ack coinciding with expiry still wins.
          if (inv_ack[idx_q]) begin
            acked_q[idx_q]   <= 1'b1;
            pending_q[idx_q] <= 1'b0;
            inv_valid_q      <= '0;
            state_q          <= SCAN;
          end else if (cnt_d >= CNT_MAX) begin
            pending_q[idx_q] <= 1'b0;
            err_flag_q       <= 1'b1;
            inv_valid_q      <= '0;
            state_q          <= SCAN;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        CLEAR: begin
          done_q  <= 1'b1;
          err_q   <= err_flag_q;
          state_q <= DONE;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign inv_valid = inv_valid_q;
  assign inv_addr  = inv_addr_q;
  assign clr_valid = clr_valid_q;
  assign clr_row   = clr_row_q;
  assign clr_mask  = clr_mask_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_l2_inval_dispatch.sv
// Directed bench for l2_inval_dispatch; cycle Tn is sampled 1ns after the n-th edge following the offer.
module tb_l2_inval_dispatch;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_valid;
  logic        start_ready;
  logic [3:0]  sharers;
  logic [1:0]  writer;
  logic [31:0] addr;
  logic [3:0]  inv_valid;
  logic [31:0] inv_addr;
  logic [3:0]  inv_ack;
  logic        clr_valid;
  logic [9:0]  clr_row;
  logic [3:0]  clr_mask;
  logic        done;
  logic        err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  l2_inval_dispatch #(
    .NPROC   (4),
    .ADDR_W  (32),
    .TIMEOUT (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .sharers     (sharers),
    .writer      (writer),
    .addr        (addr),
    .inv_valid   (inv_valid),
    .inv_addr    (inv_addr),
    .inv_ack     (inv_ack),
    .clr_valid   (clr_valid),
    .clr_row     (clr_row),
    .clr_mask    (clr_mask),
    .done        (done),
    .err         (err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start_valid = 1'b0; sharers = '0; writer = '0; addr = '0; inv_ack = '0;
    tick();
    tick();
    total++; if (start_ready !== 1'b0) begin bad++; $display("FAIL rst_ready_in_rst: got=%b exp=0", start_ready); end
    total++; if (inv_valid !== 4'b0000) begin bad++; $display("FAIL rst_inv_valid: got=%b exp=0000", inv_valid); end
    total++; if ({clr_valid, done, err} !== 3'b000) begin bad++; $display("FAIL rst_pulses: got=%b exp=000", {clr_valid, done, err}); end
    total++; if ({clr_row, clr_mask, inv_addr} !== '0) begin bad++; $display("FAIL rst_data: row=%h mask=%b addr=%h exp=0", clr_row, clr_mask, inv_addr); end
    rst = 1'b0;
    #1;
    total++; if (start_ready !== 1'b1) begin bad++; $display("FAIL rst_ready_after: got=%b exp=1", start_ready); end
    tick();
  endtask

  task automatic test_zero_sharers();
    sharers = 4'b0001; writer = 2'd0; addr = 32'h0000_0130; start_valid = 1'b1;
    total++; if (start_ready !== 1'b1) begin bad++; $display("FAIL zero_ready_t0: got=%b exp=1", start_ready); end
    for (int c = 1; c <= 4; c++) begin
      tick();
      start_valid = 1'b0;
      if (c == 1) begin total++; if (start_ready !== 1'b0) begin bad++; $display("FAIL zero_ready_t1: got=%b exp=0", start_ready); end end
      if (c <= 3) begin total++; if (inv_valid !== 4'b0000) begin bad++; $display("FAIL zero_inv_t%0d: got=%b exp=0000", c, inv_valid); end end
      if (c == 2) begin total++; if (clr_valid !== 1'b0) begin bad++; $display("FAIL zero_clr_t2: got=%b exp=0", clr_valid); end end
      if (c == 3) begin total++; if ({done, err} !== 2'b10) begin bad++; $display("FAIL zero_done_t3: done,err=%b exp=10", {done, err}); end end
      if (c == 4) begin total++; if ({done, start_ready} !== 2'b01) begin bad++; $display("FAIL zero_idle_t4: done,ready=%b exp=01", {done, start_ready}); end end
    end
  endtask

  task automatic test_two_sharers();
    sharers = 4'b1010; writer = 2'd0; addr = 32'h0000_0130; start_valid = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      start_valid = 1'b0;
      if (c == 2) begin total++; if ({inv_valid, inv_addr} !== {4'b0010, 32'h0000_0130}) begin bad++; $display("FAIL two_inv_t2: inv=%b addr=%h exp=0010 00000130", inv_valid, inv_addr); end end
      if (c == 3) begin total++; if (inv_valid !== 4'b0000) begin bad++; $display("FAIL two_gap_t3: got=%b exp=0000", inv_valid); end end
      if (c == 4) begin total++; if ({inv_valid, inv_addr} !== {4'b1000, 32'h0000_0130}) begin bad++; $display("FAIL two_inv_t4: inv=%b addr=%h exp=1000 00000130", inv_valid, inv_addr); end end
      if (c == 6) begin total++; if ({clr_valid, clr_row, clr_mask} !== {1'b1, 10'h013, 4'b1010}) begin bad++; $display("FAIL two_clr_t6: v=%b row=%h mask=%b exp=1 013 1010", clr_valid, clr_row, clr_mask); end end
      if (c == 7) begin total++; if ({done, err, clr_valid} !== 3'b100) begin bad++; $display("FAIL two_done_t7: done,err,clr=%b exp=100", {done, err, clr_valid}); end end
      inv_ack = inv_valid;
    end
    inv_ack = '0;
  endtask

  task automatic test_wrong_ack();
    sharers = 4'b0100; writer = 2'd0; addr = 32'h0000_2A40; start_valid = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      start_valid = 1'b0;
      if (c == 2 || c == 3 || c == 6) begin total++; if (inv_valid !== 4'b0100) begin bad++; $display("FAIL wrong_inv_t%0d: got=%b exp=0100", c, inv_valid); end end
      if (c == 7) begin total++; if (inv_valid !== 4'b0000) begin bad++; $display("FAIL wrong_drop_t7: got=%b exp=0000", inv_valid); end end
      if (c == 8) begin total++; if ({clr_valid, clr_row, clr_mask} !== {1'b1, 10'h2A4, 4'b0100}) begin bad++; $display("FAIL wrong_clr_t8: v=%b row=%h mask=%b exp=1 2a4 0100", clr_valid, clr_row, clr_mask); end end
      if (c == 9) begin total++; if ({done, err} !== 2'b10) begin bad++; $display("FAIL wrong_done_t9: done,err=%b exp=10", {done, err}); end end
      case (c)
        2:       inv_ack = 4'b0010;
        6:       inv_ack = 4'b0100;
        default: inv_ack = 4'b0000;
      endcase
    end
    inv_ack = '0;
  endtask

  task automatic test_timeout();
    sharers = 4'b0110; writer = 2'd0; addr = 32'h0000_0130; start_valid = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      tick();
      start_valid = 1'b0;
      if (c == 2 || c == 9) begin total++; if (inv_valid !== 4'b0010) begin bad++; $display("FAIL to_wait_t%0d: got=%b exp=0010", c, inv_valid); end end
      if (c == 10) begin total++; if (inv_valid !== 4'b0000) begin bad++; $display("FAIL to_abandon_t10: got=%b exp=0000", inv_valid); end end
      if (c == 11) begin total++; if (inv_valid !== 4'b0100) begin bad++; $display("FAIL to_next_t11: got=%b exp=0100", inv_valid); end end
      if (c == 13) begin total++; if ({clr_valid, clr_mask} !== {1'b1, 4'b0100}) begin bad++; $display("FAIL to_clr_t13: v=%b mask=%b exp=1 0100", clr_valid, clr_mask); end end
      if (c == 14) begin total++; if ({done, err} !== 2'b11) begin bad++; $display("FAIL to_done_t14: done,err=%b exp=11", {done, err}); end end
      inv_ack = inv_valid & 4'b0100;
    end
    inv_ack = '0;
  endtask

  task automatic test_reset_mid_job();
    int stray;
    sharers = 4'b0010; writer = 2'd0; addr = 32'h0000_0130; start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    tick();
    total++; if (inv_valid !== 4'b0010) begin bad++; $display("FAIL mid_wait: got=%b exp=0010", inv_valid); end
    rst = 1'b1;
    tick();
    total++; if ({inv_valid, start_ready} !== 5'b0) begin bad++; $display("FAIL mid_rst: inv,ready=%b exp=00000", {inv_valid, start_ready}); end
    rst = 1'b0;
    #1;
    total++; if (start_ready !== 1'b1) begin bad++; $display("FAIL mid_ready: got=%b exp=1", start_ready); end
    stray = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (clr_valid !== 1'b0 || done !== 1'b0) stray++;
    end
    total++; if (stray !== 0) begin bad++; $display("FAIL mid_no_pulse: cycles with clr/done=%0d exp=0", stray); end
    sharers = 4'b0011; writer = 2'd1; addr = 32'h0000_0050; start_valid = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      start_valid = 1'b0;
      if (c == 2) begin total++; if (inv_valid !== 4'b0001) begin bad++; $display("FAIL mid_new_inv: got=%b exp=0001", inv_valid); end end
      if (c == 4) begin total++; if ({clr_valid, clr_row, clr_mask} !== {1'b1, 10'h005, 4'b0001}) begin bad++; $display("FAIL mid_new_clr: v=%b row=%h mask=%b exp=1 005 0001", clr_valid, clr_row, clr_mask); end end
      if (c == 5) begin total++; if ({done, err} !== 2'b10) begin bad++; $display("FAIL mid_new_done: done,err=%b exp=10", {done, err}); end end
      inv_ack = inv_valid;
    end
    inv_ack = '0;
  endtask

  task automatic test_back_to_back();
    sharers = 4'b0100; writer = 2'd0; addr = 32'h0000_0130; start_valid = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (c == 1) begin sharers = 4'b1000; addr = 32'h0000_0FF0; end
      if (c == 2) begin total++; if ({inv_valid, inv_addr} !== {4'b0100, 32'h0000_0130}) begin bad++; $display("FAIL b2b_inv1: inv=%b addr=%h exp=0100 00000130", inv_valid, inv_addr); end end
      if (c == 4) begin total++; if ({clr_valid, clr_row, clr_mask} !== {1'b1, 10'h013, 4'b0100}) begin bad++; $display("FAIL b2b_clr1: v=%b row=%h mask=%b exp=1 013 0100", clr_valid, clr_row, clr_mask); end end
      if (c == 5) begin total++; if ({done, start_ready} !== 2'b10) begin bad++; $display("FAIL b2b_done1: done,ready=%b exp=10", {done, start_ready}); end end
      if (c == 6) begin total++; if ({start_ready, inv_valid} !== 5'b10000) begin bad++; $display("FAIL b2b_idle: ready,inv=%b exp=10000", {start_ready, inv_valid}); end end
      if (c == 7) begin total++; if (start_ready !== 1'b0) begin bad++; $display("FAIL b2b_accept2: ready=%b exp=0", start_ready); end end
      if (c == 8) begin total++; if ({inv_valid, inv_addr} !== {4'b1000, 32'h0000_0FF0}) begin bad++; $display("FAIL b2b_inv2: inv=%b addr=%h exp=1000 00000ff0", inv_valid, inv_addr); end end
      if (c == 10) begin total++; if ({clr_valid, clr_row, clr_mask} !== {1'b1, 10'h0FF, 4'b1000}) begin bad++; $display("FAIL b2b_clr2: v=%b row=%h mask=%b exp=1 0ff 1000", clr_valid, clr_row, clr_mask); end end
      if (c == 11) begin total++; if ({done, err} !== 2'b10) begin bad++; $display("FAIL b2b_done2: done,err=%b exp=10", {done, err}); end end
      if (c == 7) start_valid = 1'b0;
      inv_ack = inv_valid;
    end
    inv_ack = '0;
  endtask

  initial begin
    test_reset();
    test_zero_sharers();
    test_two_sharers();
    test_wrong_ack();
    test_timeout();
    test_reset_mid_job();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
